// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the TDM multiplexer.
//   state_e      : operating state (idle / manual select / channel scan)
//   MODE_*       : encoding of the mode input
//   next_state() : state selected by the en/mode inputs for the current cycle
package tdm_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic state_e next_state(input logic en, input logic mode);
        if (!en) begin
            return ST_IDLE;
        end
        if (mode == MODE_SCAN) begin
            return ST_SCAN;
        end
        return ST_MANUAL;
    endfunction

endpackage

// File: rtl/tdm_mux_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while run is high, then wraps to 0.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset, clears the count
//   run   : advance the count this cycle
//   clr   : synchronous clear, wins over run
//   tick  : high while running at the terminal count (DWELL-1)
module dwell_counter #(
    parameter int unsigned DWELL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    // DWELL=1 still needs a 1-bit register; it simply stays at 0.
    localparam int unsigned   CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_mux.sv
// Time-division multiplexer: presents one of N_CH packed input channels on a
// registered output, either chosen by sel (manual) or scanned in turn with
// DWELL cycles per channel (scan).
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   en         : block enable; low freezes outputs and scan position
//   mode       : 0 manual, 1 scan
//   sel        : manual channel select
//   din        : packed channels, channel k at din[k*WIDTH +: WIDTH]
//   dout, ch   : registered sample and the channel it came from
//   dout_valid : dout holds a sample taken on the last edge
//   wrap       : one-cycle pulse when scan returns to channel 0
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DWELL = 16,
    localparam int unsigned CHW   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [CHW-1:0]        sel,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout,
    output logic [CHW-1:0]        ch,
    output logic                  dout_valid,
    output logic                  wrap
);

    localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [CHW-1:0]   scan_ch_q, scan_ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             pend_q, pend_d;
    logic [CHW-1:0]   scan_ch_cur;
    logic [CHW-1:0]   rd_ch;
    logic [WIDTH-1:0] rd_data;
    logic             sel_ok;
    logic             tick;

    // The state chosen by en/mode governs the sample taken on this edge, so
    // manual data lands one cycle after sel/din.
    assign state_d = next_state(en, mode);

    // Leaving MANUAL, scanning picks up at the channel last presented.
    assign scan_ch_cur = (state_q == ST_MANUAL) ? ch_q : scan_ch_q;

    assign sel_ok  = (32'(sel) < N_CH);
    assign rd_ch   = (state_d == ST_SCAN) ? scan_ch_cur : sel;
    assign rd_data = din[rd_ch*WIDTH +: WIDTH];

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_d == ST_SCAN),
        .clr   (state_d == ST_MANUAL),
        .tick  (tick)
    );

    // pend_q remembers that the scan position wrapped to 0; wrap is raised
    // on the edge that actually presents channel 0, which may come after an
    // idle gap.
    always_comb begin
        dout_d    = dout_q;
        ch_d      = ch_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        scan_ch_d = scan_ch_q;
        pend_d    = pend_q;
        unique case (state_d)
            ST_IDLE: begin
            end
            ST_MANUAL: begin
                pend_d = 1'b0;
                if (sel_ok) begin
                    dout_d  = rd_data;
                    ch_d    = sel;
                    valid_d = 1'b1;
                end
            end
            ST_SCAN: begin
                dout_d    = rd_data;
                ch_d      = scan_ch_cur;
                valid_d   = 1'b1;
                wrap_d    = pend_q;
                pend_d    = 1'b0;
                scan_ch_d = scan_ch_cur;
                if (tick) begin
                    if (scan_ch_cur == LAST_CH) begin
                        scan_ch_d = '0;
                        pend_d    = 1'b1;
                    end else begin
                        scan_ch_d = scan_ch_cur + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dout_q    <= '0;
            ch_q      <= '0;
            scan_ch_q <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            ch_q      <= ch_d;
            scan_ch_q <= scan_ch_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
        end
    end

    assign dout       = dout_q;
    assign ch         = ch_q;
    assign dout_valid = valid_q;
    assign wrap       = wrap_q;

endmodule
